// File: rtl/uart_pkg.sv
// ------------------------------------------------------------------
// uart_pkg : constants shared by the framed-link transmitter and receiver
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int DEF_N_DADO  = 4;
  localparam int DEF_N_INSTR = 4;
  localparam int FRAME_BITS  = DEF_N_DADO + DEF_N_INSTR;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    RECEBE  = 2'd1,
    PARADA  = 2'd2,
    AGUARDA = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rx_serial_if.sv
// ------------------------------------------------------------------
// rx_serial_if : serial line in, deframed fields and strobes out
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface rx_serial_if #(
  parameter int N_DADO  = 4,
  parameter int N_INSTR = 4
);

  logic               info_entrada;
  logic [N_DADO-1:0]  dado;
  logic [N_INSTR-1:0] instrucao;
  logic               valido;
  logic               erro;
  logic               ocupado;

  modport master (
    input  info_entrada,
    output dado, instrucao, valido, erro, ocupado
  );

  modport slave (
    output info_entrada,
    input  dado, instrucao, valido, erro, ocupado
  );

endinterface

`default_nettype wire

// File: rtl/rx_serial.sv
// ------------------------------------------------------------------
// rx_serial : single-wire framed receiver, one bit per clk, LSB first
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module rx_serial
  import uart_pkg::*;
#(
  parameter int N_DADO  = DEF_N_DADO,
  parameter int N_INSTR = DEF_N_INSTR
) (
  input  logic         clk,
  input  logic         rst,
  rx_serial_if.master  bus
);

  localparam int             NBITS = N_DADO + N_INSTR;
  localparam int             CW    = $clog2(NBITS + 1);
  localparam logic [CW-1:0]  LAST  = CW'(NBITS - 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [NBITS-1:0]   shreg, shreg_nxt;
  logic [N_DADO-1:0]  dado_q, dado_nxt;
  logic [N_INSTR-1:0] instr_q, instr_nxt;
  logic               valido_q, valido_nxt;
  logic               erro_q, erro_nxt;
  logic               ocupado_q, ocupado_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= OCIOSO;
      cnt       <= '0;
      shreg     <= '0;
      dado_q    <= '0;
      instr_q   <= '0;
      valido_q  <= 1'b0;
      erro_q    <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      shreg     <= shreg_nxt;
      dado_q    <= dado_nxt;
      instr_q   <= instr_nxt;
      valido_q  <= valido_nxt;
      erro_q    <= erro_nxt;
      ocupado_q <= ocupado_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shreg_nxt  = shreg;
    dado_nxt   = dado_q;
    instr_nxt  = instr_q;
    valido_nxt = 1'b0;
    erro_nxt   = 1'b0;

    case (state)
      OCIOSO: begin
        if (!bus.info_entrada) begin
          state_nxt = RECEBE;
          cnt_nxt   = '0;
        end
      end
      RECEBE: begin
        // right shift: after NBITS shifts the first received bit sits at bit 0
        shreg_nxt = {bus.info_entrada, shreg[NBITS-1:1]};
        cnt_nxt   = cnt + CW'(1);
        if (cnt == LAST) state_nxt = PARADA;
      end
      PARADA: begin
        if (bus.info_entrada) begin
          dado_nxt   = shreg[N_DADO-1:0];
          instr_nxt  = shreg[NBITS-1:N_DADO];
          valido_nxt = 1'b1;
          state_nxt  = OCIOSO;
        end else begin
          erro_nxt  = 1'b1;
          state_nxt = AGUARDA;
        end
      end
      AGUARDA: begin
        // wait for the line to return high so a stuck-low line cannot re-arm
        if (bus.info_entrada) state_nxt = OCIOSO;
      end
      default: state_nxt = OCIOSO;
    endcase

    ocupado_nxt = (state_nxt != OCIOSO);
  end

  assign bus.dado      = dado_q;
  assign bus.instrucao = instr_q;
  assign bus.valido    = valido_q;
  assign bus.erro      = erro_q;
  assign bus.ocupado   = ocupado_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_serial.sv
// ------------------------------------------------------------------
// tb_rx_serial : directed frames with per-edge expectation schedule
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_rx_serial;

  localparam int ND   = 4;
  localparam int NI   = 4;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rx_serial_if #(.N_DADO(ND), .N_INSTR(NI)) bus ();

  rx_serial #(.N_DADO(ND), .N_INSTR(NI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expectations indexed by the posedge number after which they hold
  bit         exp_v  [MAXC];
  bit         exp_e  [MAXC];
  bit         exp_b  [MAXC];
  bit         exp_ld [MAXC];
  logic [7:0] exp_ldv[MAXC];

  logic [3:0] m_dado  = '0;
  logic [3:0] m_instr = '0;
  int n_checks = 0;
  int n_fail   = 0;
  int last_v = -1, prev_v = -1;
  int seen_v = 0, seen_e = 0;
  int want_v = 0, want_e = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      if (exp_ld[cyc]) {m_instr, m_dado} = exp_ldv[cyc];
      check("valido",    32'(bus.valido),    32'(exp_v[cyc]));
      check("erro",      32'(bus.erro),      32'(exp_e[cyc]));
      check("ocupado",   32'(bus.ocupado),   32'(exp_b[cyc]));
      check("dado",      32'(bus.dado),      32'(m_dado));
      check("instrucao", 32'(bus.instrucao), 32'(m_instr));
    end
    if (bus.valido === 1'b1) begin
      prev_v = last_v;
      last_v = cyc;
      seen_v++;
    end
    if (bus.erro === 1'b1) seen_e++;
  end

  task automatic drive(input logic b);
    @(negedge clk);
    bus.info_entrada = b;
  endtask

  // start, data LSB first, instruction LSB first, stop, then optional low hold
  task automatic send_frame(input logic [3:0] d, input logic [3:0] i,
                            input bit stop_ok, input int low_extra, input int idle);
    int e0;
    logic [7:0] bits;
    bits = {i, d};
    @(negedge clk);
    bus.info_entrada = 1'b0;
    e0 = cyc + 1;
    if (stop_ok) begin
      for (int e = e0; e <= e0 + 8; e++) if (e < MAXC) exp_b[e] = 1'b1;
      if (e0 + 9 < MAXC) begin
        exp_v[e0+9]   = 1'b1;
        exp_ld[e0+9]  = 1'b1;
        exp_ldv[e0+9] = {i, d};
      end
      want_v++;
    end else begin
      for (int e = e0; e <= e0 + 9 + low_extra; e++) if (e < MAXC) exp_b[e] = 1'b1;
      if (e0 + 9 < MAXC) exp_e[e0+9] = 1'b1;
      want_e++;
    end
    for (int k = 0; k < 8; k++) drive(bits[k]);
    drive(stop_ok ? 1'b1 : 1'b0);
    if (!stop_ok) begin
      repeat (low_extra) drive(1'b0);
      drive(1'b1);
    end
    repeat (idle) drive(1'b1);
  endtask

  task automatic apply_reset();
    #2;
    rst = 1'b0;
    m_dado  = '0;
    m_instr = '0;
    for (int e = cyc + 1; e < MAXC; e++) begin
      exp_v[e]  = 1'b0;
      exp_e[e]  = 1'b0;
      exp_b[e]  = 1'b0;
      exp_ld[e] = 1'b0;
    end
  endtask

  initial begin
    bus.info_entrada = 1'b1;
    // line toggling while held in reset must not disturb anything
    for (int k = 0; k < 6; k++) drive(k[0]);
    check("rst_ocupado", 32'(bus.ocupado), 32'd0);
    check("rst_dado",    32'(bus.dado),    32'd0);
    @(negedge clk);
    bus.info_entrada = 1'b1;
    #2 rst = 1'b1;
    repeat (3) drive(1'b1);
    check("idle_ocupado", 32'(bus.ocupado), 32'd0);

    send_frame(4'b1010, 4'b0110, 1'b1, 0, 2);
    check("nom_dado",  32'(bus.dado),      32'hA);
    check("nom_instr", 32'(bus.instrucao), 32'h6);

    send_frame(4'b1100, 4'b0011, 1'b0, 3, 2);
    check("err_dado_kept",  32'(bus.dado),      32'hA);
    check("err_instr_kept", 32'(bus.instrucao), 32'h6);
    check("err_pulses",     32'(seen_e),        32'd1);

    send_frame(4'hF, 4'h0, 1'b1, 0, 0);
    send_frame(4'h3, 4'hC, 1'b1, 0, 2);
    check("b2b_spacing", 32'(last_v - prev_v), 32'd10);
    check("b2b_dado",    32'(bus.dado),        32'h3);
    check("b2b_instr",   32'(bus.instrucao),   32'hC);

    // abort after the fourth data bit
    @(negedge clk);
    bus.info_entrada = 1'b0;
    for (int e = cyc + 1; e <= cyc + 5; e++) exp_b[e] = 1'b1;
    drive(1'b1); drive(1'b0); drive(1'b1); drive(1'b1);
    @(negedge clk);
    apply_reset();
    repeat (4) drive(1'b1);
    check("midrst_dado",    32'(bus.dado),    32'd0);
    check("midrst_ocupado", 32'(bus.ocupado), 32'd0);
    #2 rst = 1'b1;
    repeat (2) drive(1'b1);
    send_frame(4'h6, 4'h9, 1'b1, 0, 2);
    check("after_rst_dado",  32'(bus.dado),      32'h6);
    check("after_rst_instr", 32'(bus.instrucao), 32'h9);

    send_frame(4'h9, 4'h5, 1'b1, 0, 2);
    check("loop_dado",  32'(bus.dado),      32'h9);
    check("loop_instr", 32'(bus.instrucao), 32'h5);

    for (int n = 0; n < 256; n++) begin
      logic [7:0] v;
      v = 8'(n);
      send_frame(v[3:0], v[7:4], 1'b1, 0, 2);
    end
    check("loop_last_dado", 32'(bus.dado), 32'hF);

    repeat (3) drive(1'b1);
    check("valido_total", 32'(seen_v), 32'(want_v));
    check("erro_total",   32'(seen_e), 32'(want_e));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
